// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: AND/OR/NOR/ADD/SUB/LUI/SLL with a registered result.
// Define ALU_BARREL_SHIFT_EN for a single-cycle shifter; the default build shifts one bit per cycle.
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  ALUOperation,
    input  logic        Shamt,
    input  logic [4:0]  ShamtValue,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ALUResult,
    output logic        Zero,
    output logic        IllegalOp
);

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit ITERATIVE = 1'b0;
`else
    localparam bit ITERATIVE = 1'b1;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] result_reg, result_next;
    logic        zero_reg, zero_next;
    logic        illegal_reg, illegal_next;
    logic [4:0]  count_reg, count_next;

    logic [4:0]  amount;
    logic        accept;
    logic [31:0] op_result;
    logic        op_legal;
    logic [31:0] shifted;

    assign amount    = Shamt ? ShamtValue : A[4:0];
    assign in_ready  = reset && (state_reg == IDLE);
    assign accept    = in_valid && in_ready;
    assign shifted   = {result_reg[30:0], 1'b0};
    assign out_valid = (state_reg == DONE);
    assign ALUResult = result_reg;
    assign Zero      = zero_reg;
    assign IllegalOp = illegal_reg;

    // For the iterative shifter the SLL result here is only the preload value B.
    always_comb begin
        op_result = 32'h0000_0000;
        op_legal  = 1'b1;
        case (ALUOperation)
            4'b0000: op_result = A & B;
            4'b0001: op_result = A | B;
            4'b0010: op_result = ~(A | B);
            4'b0011: op_result = A + B;
            4'b0100: op_result = A - B;
            4'b0101: op_result = {B[15:0], 16'h0000};
            4'b0110: op_result = ITERATIVE ? B : (B << amount);
            default: op_legal  = 1'b0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        result_next  = result_reg;
        zero_next    = zero_reg;
        illegal_next = illegal_reg;
        count_next   = count_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    result_next  = op_result;
                    zero_next    = (op_result == 32'h0000_0000);
                    illegal_next = !op_legal;
                    count_next   = amount;
                    if (ITERATIVE && (ALUOperation == 4'b0110) && (amount != 5'd0))
                        state_next = SHIFT;
                    else
                        state_next = DONE;
                end
            end
            SHIFT: begin
                // The last shift lands on the same edge that enters DONE.
                result_next = shifted;
                count_next  = count_reg - 5'd1;
                if (count_reg == 5'd1) begin
                    state_next = DONE;
                    zero_next  = (shifted == 32'h0000_0000);
                end
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            result_reg  <= 32'h0000_0000;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            count_reg   <= 5'd0;
        end else begin
            state_reg   <= state_next;
            result_reg  <= result_next;
            zero_reg    <= zero_next;
            illegal_reg <= illegal_next;
            count_reg   <= count_next;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit; expected latencies follow ALU_BARREL_SHIFT_EN when defined.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ALUOperation = 4'd0;
    logic        Shamt = 1'b0;
    logic [4:0]  ShamtValue = 5'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        IllegalOp;

    int tests = 0;
    int fails = 0;

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    alu_exec_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOperation(ALUOperation), .Shamt(Shamt), .ShamtValue(ShamtValue),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .Zero(Zero), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input int n);
        if (BARREL || n == 0) return 1;
        return n + 1;
    endfunction

    // Issue one operation, wait for the result, complete the handshake; lat=-1 on timeout.
    task automatic run_op(input logic [3:0] op, input logic sh, input logic [4:0] shv,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output logic ill,
                          output int lat);
        int w;
        @(negedge clk);
        ALUOperation = op; Shamt = sh; ShamtValue = shv; A = a; B = b;
        in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        while (in_ready !== 1'b1 && w < 64) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
        res = ALUResult; z = Zero; ill = IllegalOp;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        in_valid = 1'b1;
        ALUOperation = 4'b0011; A = 32'd1; B = 32'd1;
        @(negedge clk);
        tests++;
        if ({out_valid, Zero, IllegalOp, in_ready} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got ov/z/ill/rdy=%b required 0000", {out_valid, Zero, IllegalOp, in_ready});
        end
        @(negedge clk);
        tests++;
        if (ALUResult !== 32'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_result: got %h ov=%b required 00000000 ov=0", ALUResult, out_valid);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
        $display("[TB] reset: ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic check_op(input string name, input logic [3:0] op, input logic sh,
                            input logic [4:0] shv, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic ez, input logic eill, input int elat);
        logic [31:0] r; logic z; logic ill; int lat;
        run_op(op, sh, shv, a, b, r, z, ill, lat);
        $display("[TB] %s: op=%b A=%h B=%h -> %h z=%b ill=%b lat=%0d", name, op, a, b, r, z, ill, lat);
        tests++;
        if (lat != elat) begin
            fails++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, elat);
        end
        tests++;
        if (r !== er || z !== ez || ill !== eill) begin
            fails++;
            $display("FAIL %s_result: got %h z=%b ill=%b required %h z=%b ill=%b", name, r, z, ill, er, ez, eill);
        end
    endtask

    task automatic test_add();
        check_op("add", 4'b0011, 1'b0, 5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1);
        check_op("add_wrap", 4'b0011, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1);
    endtask

    task automatic test_sub();
        check_op("sub", 4'b0100, 1'b0, 5'd0, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 1);
        check_op("sub_neg", 4'b0100, 1'b0, 5'd0, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    endtask

    task automatic test_logic();
        logic [3:0]  ops [3]  = '{4'b0000, 4'b0001, 4'b0010};
        logic [31:0] exps [3] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h000F_000F};
        for (int i = 0; i < 3; i++)
            check_op("logic", ops[i], 1'b0, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, exps[i], 1'b0, 1'b0, 1);
    endtask

    task automatic test_lui();
        check_op("lui", 4'b0101, 1'b0, 5'd0, 32'h0, 32'hABCD_1234, 32'h1234_0000, 1'b0, 1'b0, 1);
    endtask

    task automatic test_shift();
        check_op("sll_shamt4", 4'b0110, 1'b1, 5'd4, 32'h0, 32'h0000_00F1, 32'h0000_0F10, 1'b0, 1'b0, exp_lat(4));
        check_op("sll_from_a", 4'b0110, 1'b0, 5'd9, 32'h0000_0023, 32'h1, 32'h8, 1'b0, 1'b0, exp_lat(3));
        check_op("sll_zero_amt", 4'b0110, 1'b1, 5'd0, 32'h0, 32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0, exp_lat(0));
        check_op("sll_31", 4'b0110, 1'b1, 5'd31, 32'h0, 32'h3, 32'h8000_0000, 1'b0, 1'b0, exp_lat(31));
        check_op("sll_out", 4'b0110, 1'b1, 5'd1, 32'h0, 32'h8000_0000, 32'h0, 1'b1, 1'b0, exp_lat(1));
    endtask

    task automatic test_illegal_backpressure();
        @(negedge clk);
        ALUOperation = 4'b1001; Shamt = 1'b0; A = 32'h55; B = 32'hAA;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // A fresh request while DONE must be ignored.
        ALUOperation = 4'b0011; A = 32'd1; B = 32'd1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            tests++;
            if ({out_valid, Zero, IllegalOp, in_ready} !== 4'b1110 || ALUResult !== 32'd0) begin
                fails++;
                $display("FAIL illegal_hold%0d: got ov/z/ill/rdy=%b res=%h required 1110 res=00000000",
                         i, {out_valid, Zero, IllegalOp, in_ready}, ALUResult);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL illegal_release: got ov=%b rdy=%b required ov=0 rdy=1", out_valid, in_ready);
        end
        $display("[TB] illegal 1001 with backpressure: released ov=%b rdy=%b", out_valid, in_ready);
        check_op("illegal_1111", 4'b1111, 1'b0, 5'd0, 32'h1, 32'h2, 32'h0, 1'b1, 1'b1, 1);
        check_op("legal_clears", 4'b0011, 1'b0, 5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        logic exp_rdy [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic exp_ov  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        ALUOperation = 4'b0011; A = 32'd5; B = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            tests++;
            if (in_ready !== exp_rdy[i] || out_valid !== exp_ov[i] || (exp_ov[i] && ALUResult !== 32'd8)) begin
                fails++;
                $display("FAIL b2b_cycle%0d: got rdy=%b ov=%b res=%h required rdy=%b ov=%b res=00000008",
                         i, in_ready, out_valid, ALUResult, exp_rdy[i], exp_ov[i]);
            end
            $display("[TB] back_to_back cycle %0d: rdy=%b ov=%b res=%h", i, in_ready, out_valid, ALUResult);
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        ALUOperation = 4'b0110; Shamt = 1'b1; ShamtValue = 5'd31; B = 32'h1;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (c > 1) @(negedge clk);
            tests++;
            if (out_valid !== BARREL) begin
                fails++;
                $display("FAIL midshift_cycle%0d: got ov=%b required %b", c, out_valid, BARREL);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || ALUResult !== 32'd0 || in_ready !== 1'b0 || Zero !== 1'b0) begin
            fails++;
            $display("FAIL midshift_reset: got ov=%b res=%h rdy=%b z=%b required 0 00000000 0 0",
                     out_valid, ALUResult, in_ready, Zero);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ALUResult !== 32'd0) begin
            fails++;
            $display("FAIL midshift_release: got rdy=%b ov=%b res=%h required 1 0 00000000",
                     in_ready, out_valid, ALUResult);
        end
        $display("[TB] mid-shift reset: rdy=%b ov=%b res=%h", in_ready, out_valid, ALUResult);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_lui();
        test_shift();
        test_illegal_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
